fetch_sequencer: RTL

Controller for the instruction fetch stage. It owns the program counter and issues word fetches to instruction memory over a req/ready handshake. Each returned word is held in the IF/ID output slot under a valid/ready handshake with decode. Branch redirects arrive from execute and flush the slot. The block sits between the instruction memory and the IF/ID boundary, replacing the free-running fetch PC with a stall-aware, flushable sequencer.

---
 rtl/fetch_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues word fetches over a req/ready
// handshake and holds each returned word in the IF/ID slot for decode.
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          IMEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic [63:0] branchAddr,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    output logic [63:0] PC,
    output logic        halted,
    output logic        misaligned,
    output logic [31:0] fetch_count
);

    localparam logic [63:0] REGION_END = RESET_PC + (64'(IMEM_WORDS) * 64'd4);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HALT
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [63:0] if_pc_q, if_pc_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        req_c;
    logic        slot_free;
    logic        fetch_fire;
    logic        consume;
    logic [63:0] pc_plus4;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        misaligned_d  = misaligned_q;
        fetch_count_d = fetch_count_q;
        req_c         = 1'b0;

        consume    = if_valid_q && id_ready;
        slot_free  = !if_valid_q || id_ready;
        pc_plus4   = pc_q + 64'd4;

        case (state_q)
            IDLE:    state_d = REQ;
            REQ:     req_c   = slot_free;
            HALT:    req_c   = 1'b0;
            default: state_d = IDLE;
        endcase

        fetch_fire = req_c && imem_ready;

        // Delivery is counted before any flush, so a word taken in a redirect cycle still counts
        if (consume) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end

        if (PCSrc) begin
            pc_d       = branchAddr;
            if_valid_d = 1'b0;
            if (branchAddr[1:0] == 2'b00) begin
                state_d      = REQ;
                misaligned_d = 1'b0;
            end else begin
                state_d      = HALT;
                misaligned_d = 1'b1;
            end
        end else if (fetch_fire) begin
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_plus4;
            if (pc_plus4 >= REGION_END) begin
                state_d = HALT;
            end
        end else if (consume) begin
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_instr_q    <= 32'd0;
            if_pc_q       <= 64'd0;
            misaligned_q  <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            misaligned_q  <= misaligned_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_req    = req_c;
    assign imem_addr   = pc_q;
    assign PC          = pc_q;
    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign halted      = (state_q == HALT);
    assign misaligned  = misaligned_q;
    assign fetch_count = fetch_count_q;

endmodule
